// File: rtl/uart_rx_os16_if.sv
// Receive-side handshake bundle for uart_rx_os16.
//   master : the receiver; drives the held byte, its error flags and rx_valid,
//            and observes rx_ready from the consumer.
//   slave  : the consumer (loopback checker or CPU-side test driver); accepts
//            the held byte on any clk edge where rx_valid & rx_ready.
// Signals:
//   rx_data      held received byte (DATA_BITS wide)
//   rx_valid     holding register full
//   rx_ready     consumer accepts this edge
//   framing_err  stop bit sampled 0 for the held byte
//   parity_err   parity mismatch for the held byte
//   overrun_err  sticky: a completed frame was dropped while the register was full
interface uart_rx_os16_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 framing_err;
  logic                 parity_err;
  logic                 overrun_err;

  modport master (
    output rx_data,
    output rx_valid,
    output framing_err,
    output parity_err,
    output overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  framing_err,
    input  parity_err,
    input  overrun_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_os16.sv
// Oversampling asynchronous serial receiver for the 6850 ACIA TxData line.
// Recovers LSB-first frames (start, DATA_BITS data, optional parity, stop)
// from an idle-high line using a baud_tick enable at OVERSAMPLE x baud, and
// hands each byte plus its error flags to a one-entry holding register.
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   baud_tick  one-clk enable pulse at OVERSAMPLE x baud
//   rxd        asynchronous serial input, idle high
//   busy       receiver is in the middle of a frame (FSM not idle)
//   rx         master side of uart_rx_os16_if (rx_data, rx_valid, rx_ready,
//              framing_err, parity_err, overrun_err)
// Parameters:
//   DATA_BITS   5..8 data bits per frame
//   PARITY      0 none, 1 even, 2 odd
//   OVERSAMPLE  ticks per bit, even and >= 4
//   SYNC_STAGES rxd synchroniser depth, >= 2
module uart_rx_os16 #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           baud_tick,
  input  logic           rxd,
  output logic           busy,
  uart_rx_os16_if.master rx
);

  localparam int                TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic              PAR_ODD   = (PARITY == 2);
  localparam logic              PAR_ON    = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  state_t                 state;
  logic [TICK_W-1:0]      tick_cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_err_q;
  logic                   busy_q;

  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   perr_q;
  logic                   ovr_q;
  logic                   accept;

  // Synchroniser: resets to idle-high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rxs    = sync_q[SYNC_STAGES-1];
  assign accept = valid_q & rx.rx_ready;

  // Receive FSM and holding register. The accept clear is written first so a
  // commit on the same edge (later assignment) takes precedence for
  // rx_valid/flags while overrun_err stays cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      if (accept) begin
        valid_q <= 1'b0;
        ferr_q  <= 1'b0;
        perr_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end

      if (baud_tick) begin
        unique case (state)
          S_IDLE: begin
            if (!rxs) begin
              state    <= S_START;
              tick_cnt <= '0;
              busy_q   <= 1'b1;
            end
          end

          S_START: begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              if (rxs) begin
                // Line went back high before mid start bit: a glitch.
                state  <= S_IDLE;
                busy_q <= 1'b0;
              end else begin
                state   <= S_DATA;
                bit_cnt <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          S_DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shift_q  <= {rxs, shift_q[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                state <= PAR_ON ? S_PARITY : S_STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          S_PARITY: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt  <= '0;
              par_err_q <= (^shift_q) ^ rxs ^ PAR_ODD;
              state     <= S_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          S_STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (!valid_q || rx.rx_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
                ferr_q  <= ~rxs;
                perr_q  <= PAR_ON ? par_err_q : 1'b0;
              end else begin
                ovr_q <= 1'b1;
              end
              // A low stop bit means break or framing fault: wait for the line
              // to return high so the same low level is not taken as a start.
              state  <= rxs ? S_IDLE : S_BRK_WAIT;
              busy_q <= ~rxs;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          S_BRK_WAIT: begin
            if (rxs) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end

          default: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy           = busy_q;
  assign rx.rx_data     = data_q;
  assign rx.rx_valid    = valid_q;
  assign rx.framing_err = ferr_q;
  assign rx.parity_err  = perr_q;
  assign rx.overrun_err = ovr_q;

endmodule
